// File: rtl/acc_arb_pkg.sv
// acc_arb_pkg: shared types, defaults and helpers for the accelerator port arbiter.
package acc_arb_pkg;

  // Default geometry of the simple_acc register port
  localparam int ACC_AWIDTH_DEF    = 4;
  localparam int ACC_DWIDTH_DEF    = 32;
  localparam int ACC_MAX_BURST_DEF = 4;

  // Requester ids fit in two bits (at most four requesters)
  localparam int MAX_REQ  = 4;
  localparam int ARB_ID_W = 2;

  // Burst counter wide enough for a cap of 15
  localparam int BURST_W = 4;

  // Response tag: which requester gets the completion pulse next cycle
  typedef struct packed {
    logic                valid;
    logic [ARB_ID_W-1:0] id;
  } rsp_tag_t;

  // Round-robin winner: first set bit of valid searching ptr, ptr+1, ... mod n.
  // Returns ptr when nothing is valid.
  function automatic logic [ARB_ID_W-1:0] rr_winner(
    input logic [MAX_REQ-1:0]  valid,
    input logic [ARB_ID_W-1:0] ptr,
    input int                  n
  );
    int idx;
    rr_winner = ptr;
    for (int k = n - 1; k >= 0; k--) begin
      idx = (int'(ptr) + k) % n;
      if (valid[idx]) rr_winner = ARB_ID_W'(idx);
    end
  endfunction

endpackage

// File: rtl/rr_pick.sv
// rr_pick: combinational round-robin pick. Rotates the request vector so the
// pointer lands at bit 0, priority-encodes the lowest set bit, then rotates the
// index back. Reusable for any arbiter with N requesters.
module rr_pick #(
  parameter int N  = 2,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  valid,
  input  logic [PW-1:0] ptr,
  output logic          any,
  output logic [PW-1:0] win,
  output logic [N-1:0]  grant
);

  logic [2*N-1:0] dbl;
  logic [N-1:0]   rot;
  logic [PW-1:0]  idx;
  logic [PW:0]    sum;

  assign dbl = {valid, valid};
  assign rot = dbl[ptr +: N];
  assign any = |valid;

  // Lowest set bit of the rotated vector is the closest requester after ptr
  always_comb begin
    idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (rot[i]) idx = PW'(i);
    end
  end

  // Undo the rotation: (idx + ptr) mod N without a divider
  assign sum = {1'b0, idx} + {1'b0, ptr};
  assign win = (sum >= (PW+1)'(N)) ? PW'(sum - (PW+1)'(N)) : sum[PW-1:0];

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_grant
      assign grant[gi] = any & (win == PW'(gi));
    end
  endgenerate

endmodule

// File: rtl/acc_port_arbiter.sv
// acc_port_arbiter: shares the simple_acc register port (1-cycle read latency)
// among NUM_REQ requesters. Round-robin with a burst cap; a winner keeps
// priority (streaming) until MAX_BURST grants while others wait. Each accepted
// access gets a one-cycle rsp_valid pulse routed back to its requester.
// Optional: define ACC_ARB_LOCK_EN to add req_lock, letting the current owner
// hold the port exclusively.
module acc_port_arbiter
  import acc_arb_pkg::*;
#(
  parameter int NUM_REQ   = 2,
  parameter int AWIDTH    = ACC_AWIDTH_DEF,
  parameter int DWIDTH    = ACC_DWIDTH_DEF,
  parameter int MAX_BURST = ACC_MAX_BURST_DEF
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ-1:0]        req_we,
  input  logic [NUM_REQ*AWIDTH-1:0] req_addr,
  input  logic [NUM_REQ*DWIDTH-1:0] req_wdata,
`ifdef ACC_ARB_LOCK_EN
  input  logic [NUM_REQ-1:0]        req_lock,
`endif
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic [DWIDTH-1:0]         rsp_rdata,
  output logic [AWIDTH-1:0]         acc_addr,
  output logic                      acc_en,
  output logic                      acc_we,
  output logic [DWIDTH-1:0]         acc_din,
  input  logic [DWIDTH-1:0]         acc_dout
);

  localparam int                PW        = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [BURST_W:0]  BURST_CAP = (BURST_W+1)'(MAX_BURST);
  localparam logic [PW-1:0]     LAST_ID   = PW'(NUM_REQ - 1);

  function automatic logic [PW-1:0] next_id(input logic [PW-1:0] id);
    return (id == LAST_ID) ? '0 : id + PW'(1);
  endfunction

  logic [PW-1:0]      ptr_reg;
  logic [PW-1:0]      last_id_reg;
  logic [BURST_W-1:0] burst_cnt_reg;
  rsp_tag_t           tag_reg;
  logic               rd_pend_reg;
  logic [DWIDTH-1:0]  rdata_hold_reg;
  logic [DWIDTH-1:0]  din_hold_reg;
  logic [AWIDTH-1:0]  addr_hold_reg;

  logic [NUM_REQ-1:0] arb_valid;
  logic [NUM_REQ-1:0] pick_grant;
  logic [PW-1:0]      search_ptr;
  logic [PW-1:0]      win;
  logic               pick_any;
  logic               accept;
  logic               rotate_ok;
  logic               others_waiting;
  logic               rsp_fire;
  logic [BURST_W:0]   cnt_new;

  genvar gi;

`ifdef ACC_ARB_LOCK_EN
  logic owner_vld_reg;
  logic locked_reg;
  logic locked;
  logic lock_release;

  // The owner is the last granted requester; only it may use the port while locked
  assign locked       = owner_vld_reg & req_lock[last_id_reg];
  assign lock_release = locked_reg & ~locked;
  assign search_ptr   = lock_release ? next_id(last_id_reg) : ptr_reg;
  assign rotate_ok    = ~locked;

  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_lock_mask
      assign arb_valid[gi] = req_valid[gi] & (~locked | (last_id_reg == PW'(gi)));
    end
  endgenerate

  // Remember whether anyone has owned the port and whether it was locked last cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      owner_vld_reg <= 1'b0;
      locked_reg    <= 1'b0;
    end else begin
      if (accept) owner_vld_reg <= 1'b1;
      locked_reg <= locked;
    end
  end
`else
  assign search_ptr = ptr_reg;
  assign rotate_ok  = 1'b1;
  assign arb_valid  = req_valid;
`endif

  rr_pick #(
    .N  (NUM_REQ),
    .PW (PW)
  ) u_pick (
    .valid (arb_valid),
    .ptr   (search_ptr),
    .any   (pick_any),
    .win   (win),
    .grant (pick_grant)
  );

  // Nothing is granted while reset is held
  assign accept    = pick_any & ~rst;
  assign req_ready = pick_grant & {NUM_REQ{~rst}};

  // The winner drives the accelerator in its accept cycle; addr/din hold otherwise
  assign acc_en   = accept;
  assign acc_we   = accept & req_we[win];
  assign acc_addr = accept ? req_addr[win*AWIDTH +: AWIDTH]  : addr_hold_reg;
  assign acc_din  = accept ? req_wdata[win*DWIDTH +: DWIDTH] : din_hold_reg;

  assign others_waiting = rotate_ok & (|(req_valid & ~pick_grant));
  assign cnt_new = (win == last_id_reg) ? ({1'b0, burst_cnt_reg} + (BURST_W+1)'(1))
                                        : (BURST_W+1)'(1);

  // Completion pulse the cycle after accept; read data passes straight from acc_dout
  assign rsp_fire  = tag_reg.valid & ~rst;
  assign rsp_rdata = (rsp_fire & rd_pend_reg) ? acc_dout : rdata_hold_reg;

  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_rsp
      assign rsp_valid[gi] = rsp_fire & (tag_reg.id == ARB_ID_W'(gi));
    end
  endgenerate

  // Response tag, held read data, port hold values, pointer and burst bookkeeping
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_reg        <= '0;
      last_id_reg    <= '0;
      burst_cnt_reg  <= '0;
      tag_reg        <= '0;
      rd_pend_reg    <= 1'b0;
      rdata_hold_reg <= '0;
      addr_hold_reg  <= '0;
      din_hold_reg   <= '0;
    end else begin
      tag_reg.valid <= accept;
      tag_reg.id    <= ARB_ID_W'(win);
      rd_pend_reg   <= accept & ~req_we[win];
      if (rsp_fire & rd_pend_reg) rdata_hold_reg <= acc_dout;
      if (accept) begin
        addr_hold_reg <= acc_addr;
        din_hold_reg  <= acc_din;
        last_id_reg   <= win;
        if ((cnt_new >= BURST_CAP) && others_waiting) begin
          ptr_reg       <= next_id(win);
          burst_cnt_reg <= '0;
        end else begin
          ptr_reg       <= win;
          burst_cnt_reg <= (cnt_new > BURST_CAP) ? BURST_CAP[BURST_W-1:0]
                                                 : cnt_new[BURST_W-1:0];
        end
      end
`ifdef ACC_ARB_LOCK_EN
      else if (lock_release) begin
        ptr_reg <= search_ptr;
      end
`endif
    end
  end

endmodule

// File: tb/tb_acc_port_arbiter.sv
// tb_acc_port_arbiter: randomized and directed bench for acc_port_arbiter with a
// behavioural reference model (round-robin search over ints, burst rules,
// memory image) and a simple accelerator model with 1-cycle read latency.
module tb_acc_port_arbiter;

  localparam int N  = 2;
  localparam int AW = 4;
  localparam int DW = 32;
  localparam int MB = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [N-1:0]      req_valid = '0;
  logic [N-1:0]      req_we = '0;
  logic [N*AW-1:0]   req_addr = '0;
  logic [N*DW-1:0]   req_wdata = '0;
  logic [N-1:0]      req_ready;
  logic [N-1:0]      rsp_valid;
  logic [DW-1:0]     rsp_rdata;
  logic [AW-1:0]     acc_addr;
  logic              acc_en;
  logic              acc_we;
  logic [DW-1:0]     acc_din;
  logic [DW-1:0]     acc_dout = '0;
`ifdef ACC_ARB_LOCK_EN
  logic [N-1:0]      req_lock = '0;
`endif

  acc_port_arbiter #(
    .NUM_REQ   (N),
    .AWIDTH    (AW),
    .DWIDTH    (DW),
    .MAX_BURST (MB)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
`ifdef ACC_ARB_LOCK_EN
    .req_lock  (req_lock),
`endif
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .acc_addr  (acc_addr),
    .acc_en    (acc_en),
    .acc_we    (acc_we),
    .acc_din   (acc_din),
    .acc_dout  (acc_dout)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] mem_init_val(input int i);
    return (i == 3) ? 32'hDEADBEEF : (32'hA5000000 | 32'(i));
  endfunction

  // Accelerator: register file, read data valid one cycle after the read
  logic [DW-1:0] acc_mem [16];
  logic          mem_init_done = 1'b0;
  always @(posedge clk) begin
    if (!mem_init_done) begin
      for (int i = 0; i < 16; i++) acc_mem[i] <= mem_init_val(i);
      mem_init_done <= 1'b1;
    end else if (acc_en) begin
      if (acc_we) acc_mem[acc_addr] <= acc_din;
      else        acc_dout <= acc_mem[acc_addr];
    end
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference model state
  logic [DW-1:0] ref_mem [16];
  int            m_ptr, m_last, m_cnt;
  bit            m_tag_valid, m_tag_rd;
  int            m_tag_id;
  logic [DW-1:0] m_tag_data, m_hold;
  logic [AW-1:0] m_addr_hold;
  logic [DW-1:0] m_din_hold;
  logic [N-1:0]  last_exp_ready = '0;
  int            dut_glog[$];
  int            exp_g [9] = '{0, 0, 0, 0, 1, 1, 1, 1, 0};

  task automatic model_reset();
    m_ptr = 0; m_last = -1; m_cnt = 0;
    m_tag_valid = 0; m_tag_rd = 0; m_tag_id = 0;
    m_tag_data = '0; m_hold = '0; m_addr_hold = '0; m_din_hold = '0;
    last_exp_ready = '0;
  endtask

  function automatic int model_winner(input logic [N-1:0] v, input int p);
    for (int k = 0; k < N; k++) if (v[(p + k) % N]) return (p + k) % N;
    return -1;
  endfunction

  // Compare this cycle's outputs with the model, then advance the model
  task automatic check_cycle();
    int            w, nc;
    bit            others;
    logic [N-1:0]  exp_ready, exp_rsp;
    logic [AW-1:0] ad;
    logic [DW-1:0] wd;
    w = model_winner(req_valid, m_ptr);
    exp_ready = '0;
    if (w >= 0) exp_ready[w] = 1'b1;
    exp_rsp = '0;
    if (m_tag_valid) exp_rsp[m_tag_id] = 1'b1;
    chk("req_ready", 64'(req_ready), 64'(exp_ready));
    chk("acc_en", 64'(acc_en), 64'(w >= 0));
    chk("acc_we", 64'(acc_we), 64'((w >= 0) && req_we[w]));
    if (w >= 0) begin
      ad = req_addr[w*AW +: AW];
      wd = req_wdata[w*DW +: DW];
    end else begin
      ad = m_addr_hold;
      wd = m_din_hold;
    end
    chk("acc_addr", 64'(acc_addr), 64'(ad));
    chk("acc_din", 64'(acc_din), 64'(wd));
    chk("rsp_valid", 64'(rsp_valid), 64'(exp_rsp));
    chk("rsp_rdata", 64'(rsp_rdata), 64'((m_tag_valid && m_tag_rd) ? m_tag_data : m_hold));

    for (int i = 0; i < N; i++) if (req_ready[i]) dut_glog.push_back(i);

    if (m_tag_valid && m_tag_rd) m_hold = m_tag_data;
    m_tag_valid = 0;
    if (w >= 0) begin
      $display("txn t=%0t req=%0d %s addr=0x%0h data=0x%0h", $time, w,
               req_we[w] ? "WR" : "RD", ad, req_we[w] ? wd : ref_mem[ad]);
      m_tag_valid = 1; m_tag_id = w; m_tag_rd = !req_we[w];
      if (req_we[w]) ref_mem[ad] = wd;
      else           m_tag_data = ref_mem[ad];
      m_addr_hold = ad; m_din_hold = wd;
      nc = (w == m_last) ? m_cnt + 1 : 1;
      others = 0;
      for (int j = 0; j < N; j++) if (j != w && req_valid[j]) others = 1;
      if (nc >= MB && others) begin
        m_ptr = (w + 1) % N; m_cnt = 0;
      end else begin
        m_ptr = w; m_cnt = (nc > MB) ? MB : nc;
      end
      m_last = w;
    end
    last_exp_ready = exp_ready;
  endtask

  task automatic step(input logic [N-1:0] v, input logic [N-1:0] we,
                      input logic [N*AW-1:0] a, input logic [N*DW-1:0] d);
    @(posedge clk); #1;
    req_valid = v; req_we = we; req_addr = a; req_wdata = d;
    @(negedge clk);
    check_cycle();
  endtask

  initial begin
    logic [N-1:0]    v, we;
    logic [N*AW-1:0] a;
    logic [N*DW-1:0] d;
    for (int i = 0; i < 16; i++) ref_mem[i] = mem_init_val(i);
    model_reset();

    // Reset state
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_ready", 64'(req_ready), 64'(0));
    chk("rst_rsp_valid", 64'(rsp_valid), 64'(0));
    chk("rst_acc_en", 64'(acc_en), 64'(0));
    chk("rst_acc_we", 64'(acc_we), 64'(0));
    chk("rst_acc_addr", 64'(acc_addr), 64'(0));
    chk("rst_acc_din", 64'(acc_din), 64'(0));
    chk("rst_rsp_rdata", 64'(rsp_rdata), 64'(0));

    // Single read of addr 3 by req0
    step(2'b01, 2'b00, {4'd0, 4'd3}, '0);
    chk("t1_ready", 64'(req_ready), 64'(2'b01));
    chk("t1_addr", 64'(acc_addr), 64'(3));
    step(2'b00, 2'b00, '0, '0);
    chk("t1_rsp_valid", 64'(rsp_valid), 64'(2'b01));
    chk("t1_rdata", 64'(rsp_rdata), 64'(32'hDEADBEEF));

    // Write ack from req1
    step(2'b10, 2'b10, {4'd5, 4'd0}, {32'h12345678, 32'h0});
    chk("t2_acc_we", 64'(acc_we), 64'(1));
    chk("t2_acc_din", 64'(acc_din), 64'(32'h12345678));
    step(2'b00, 2'b00, '0, '0);
    chk("t2_rsp_valid", 64'(rsp_valid), 64'(2'b10));
    chk("t2_rdata_kept", 64'(rsp_rdata), 64'(32'hDEADBEEF));

    // Back-to-back read/write/read from req0
    step(2'b01, 2'b00, {4'd0, 4'd1}, '0);
    step(2'b01, 2'b01, {4'd0, 4'd2}, {32'h0, 32'hCAFE0002});
    chk("t3_rsp1", 64'(rsp_valid), 64'(2'b01));
    step(2'b01, 2'b00, {4'd0, 4'd3}, '0);
    chk("t3_rsp2", 64'(rsp_valid), 64'(2'b01));
    step(2'b00, 2'b00, '0, '0);
    chk("t3_rsp3", 64'(rsp_valid), 64'(2'b01));

    // Reset in the cycle after a read by req1 is accepted
    step(2'b10, 2'b00, {4'd7, 4'd0}, '0);
    @(posedge clk); #1;
    rst = 1'b1; req_valid = '0;
    @(negedge clk);
    chk("mid_rst_rsp_valid", 64'(rsp_valid), 64'(0));
    chk("mid_rst_ready", 64'(req_ready), 64'(0));
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    @(negedge clk);
    chk("post_rst_rsp_valid", 64'(rsp_valid), 64'(0));
    chk("post_rst_acc_addr", 64'(acc_addr), 64'(0));
    chk("post_rst_rdata", 64'(rsp_rdata), 64'(0));

    // Contention straight out of reset: both valid continuously
    dut_glog.delete();
    for (int i = 0; i < 9; i++) step(2'b11, 2'b00, {4'd9, 4'd8}, '0);
    chk("contention_count", 64'(dut_glog.size()), 64'(9));
    for (int i = 0; i < 9 && i < dut_glog.size(); i++)
      chk($sformatf("contention_grant%0d", i), 64'(dut_glog[i]), 64'(exp_g[i]));

    // Randomized traffic; pending requests keep their payload or are dropped
    for (int c = 0; c < 400; c++) begin
      v = req_valid; we = req_we; a = req_addr; d = req_wdata;
      for (int i = 0; i < N; i++) begin
        if (req_valid[i] && !last_exp_ready[i]) begin
          if ($urandom_range(0, 9) == 0) v[i] = 1'b0;
        end else begin
          v[i]           = ($urandom_range(0, 2) != 0);
          we[i]          = 1'($urandom_range(0, 1));
          a[i*AW +: AW]  = AW'($urandom_range(0, 15));
          d[i*DW +: DW]  = $urandom;
        end
      end
      step(v, we, a, d);
    end
    step(2'b00, 2'b00, '0, '0);
    step(2'b00, 2'b00, '0, '0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
